te_periodic_sync_gen: RTL and testbench

Parametrised periodic-synchronisation request generator for the trace encoder. It counts packets, cycles or retired instructions according to a runtime-selected InstSyncMode_e. When the programmed period is reached, it raises a PERIODIC_SYNC request to the packetiser. It sits between the retire interface / packet emitter and the Nexus packet builder, and adds what the fixed sync counter lacks: per-cycle multi-instruction increments, a req/ack handshake, sync-packet restart, and missed-sync detection.

---
 rtl/te_periodic_sync_gen.sv | 137 +++++++++++++
 tb/tb_te_periodic_sync_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/te_periodic_sync_gen.sv
// Periodic PERIODIC_SYNC request generator: counts packets, cycles or retired instructions up to a programmable period.
// Latency: a threshold hit at edge N raises sync_req_o from cycle N+1; the request holds until acked (req && ack).
module te_periodic_sync_gen #(
    parameter int COUNT_WIDTH   = 20,
    parameter int RETIRE_WIDTH  = 4,
    parameter int IRETIRE_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     trace_enable_i,
    input  logic [1:0]               sync_mode_i,
    input  logic [COUNT_WIDTH-1:0]   sync_period_i,
    input  logic                     inst_retire_valid_i,
    input  logic [IRETIRE_WIDTH-1:0] inst_retire_cnt_i,
    input  logic                     pkt_emit_valid_i,
    input  logic                     pkt_emit_is_sync_i,
    output logic                     sync_req_o,
    output logic [3:0]               sync_cause_o,
    input  logic                     sync_ack_i,
    output logic                     sync_missed_o,
    output logic [COUNT_WIDTH-1:0]   count_o
);

    typedef enum logic [1:0] {
        SYNC_OFF      = 2'd0,
        PKT_COUNT     = 2'd1,
        CYCLE_COUNT   = 2'd2,
        IRETIRE_COUNT = 2'd3
    } inst_sync_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

    localparam logic [3:0]               CAUSE_PERIODIC_SYNC = 4'h2;
    localparam logic [IRETIRE_WIDTH-1:0] RETIRE_MAX          = IRETIRE_WIDTH'(RETIRE_WIDTH);

    state_e                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     missed_q, missed_d;
    logic [1:0]               mode_q;
    logic [COUNT_WIDTH-1:0]   period_q;

    logic                     idle;
    logic                     reconfig;
    logic                     sync_pkt;
    logic [IRETIRE_WIDTH-1:0] retire_clamped;
    logic [COUNT_WIDTH:0]     inc;
    logic [COUNT_WIDTH:0]     sum;
    logic                     hit;

    assign idle     = !trace_enable_i || (sync_mode_i == SYNC_OFF) || (sync_period_i == '0);
    assign reconfig = (sync_mode_i != mode_q) || (sync_period_i != period_q);
    assign sync_pkt = pkt_emit_valid_i && pkt_emit_is_sync_i;

    assign retire_clamped = (inst_retire_cnt_i > RETIRE_MAX) ? RETIRE_MAX : inst_retire_cnt_i;

    always_comb begin
        inc = '0;
        case (inst_sync_mode_e'(sync_mode_i))
            PKT_COUNT:     inc = (COUNT_WIDTH+1)'(pkt_emit_valid_i && !pkt_emit_is_sync_i);
            CYCLE_COUNT:   inc = (COUNT_WIDTH+1)'(1);
            IRETIRE_COUNT: inc = inst_retire_valid_i ? (COUNT_WIDTH+1)'(retire_clamped) : '0;
            default:       inc = '0;
        endcase
    end

    // One extra bit keeps the sum from wrapping, so the compare is always exact.
    assign sum = {1'b0, count_q} + inc;
    assign hit = (sum >= {1'b0, period_q});

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        missed_d = missed_q;
        if (idle) begin
            state_d = ST_IDLE;
            count_d = '0;
            if (!trace_enable_i) begin
                missed_d = 1'b0;
            end
        end else if (reconfig || sync_pkt) begin
            state_d = ST_COUNT;
            count_d = '0;
        end else begin
            case (state_q)
                ST_PENDING: begin
                    if (hit) begin
                        count_d = '0;
                        // Ack in the same cycle consumes the old request; the new hit re-raises it.
                        if (!sync_ack_i) begin
                            missed_d = 1'b1;
                        end
                    end else begin
                        count_d = sum[COUNT_WIDTH-1:0];
                        if (sync_ack_i) begin
                            state_d = ST_COUNT;
                        end
                    end
                end
                default: begin
                    if (hit) begin
                        state_d = ST_PENDING;
                        count_d = '0;
                    end else begin
                        state_d = ST_COUNT;
                        count_d = sum[COUNT_WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            missed_q <= 1'b0;
            mode_q   <= sync_mode_i;
            period_q <= sync_period_i;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            missed_q <= missed_d;
            mode_q   <= sync_mode_i;
            period_q <= sync_period_i;
        end
    end

    assign sync_req_o    = (state_q == ST_PENDING);
    assign sync_cause_o  = sync_req_o ? CAUSE_PERIODIC_SYNC : 4'h0;
    assign sync_missed_o = missed_q;
    assign count_o       = count_q;

endmodule

// File: tb/tb_te_periodic_sync_gen.sv
// Directed vector bench for te_periodic_sync_gen with hand-computed expectations.
module tb_te_periodic_sync_gen;

    logic        clk;
    logic        reset;
    logic        trace_enable;
    logic [1:0]  sync_mode;
    logic [19:0] sync_period;
    logic        inst_retire_valid;
    logic [3:0]  inst_retire_cnt;
    logic        pkt_emit_valid;
    logic        pkt_emit_is_sync;
    logic        sync_req;
    logic [3:0]  sync_cause;
    logic        sync_ack;
    logic        sync_missed;
    logic [19:0] count;

    te_periodic_sync_gen #(
        .COUNT_WIDTH  (20),
        .RETIRE_WIDTH (4),
        .IRETIRE_WIDTH(4)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .trace_enable_i     (trace_enable),
        .sync_mode_i        (sync_mode),
        .sync_period_i      (sync_period),
        .inst_retire_valid_i(inst_retire_valid),
        .inst_retire_cnt_i  (inst_retire_cnt),
        .pkt_emit_valid_i   (pkt_emit_valid),
        .pkt_emit_is_sync_i (pkt_emit_is_sync),
        .sync_req_o         (sync_req),
        .sync_cause_o       (sync_cause),
        .sync_ack_i         (sync_ack),
        .sync_missed_o      (sync_missed),
        .count_o            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        te;
        logic [1:0]  mode;
        logic [19:0] per;
        logic        rv;
        logic [3:0]  rc;
        logic        pv;
        logic        ps;
        logic        ack;
        logic        ereq;
        logic        emiss;
        logic [19:0] ecnt;
    } vec_t;

    vec_t vq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic vec_t mk(logic rst, logic te, logic [1:0] mode, logic [19:0] per,
                                logic rv, logic [3:0] rc, logic pv, logic ps, logic ack,
                                logic ereq, logic emiss, logic [19:0] ecnt);
        vec_t v;
        v.rst = rst; v.te = te; v.mode = mode; v.per = per;
        v.rv = rv; v.rc = rc; v.pv = pv; v.ps = ps; v.ack = ack;
        v.ereq = ereq; v.emiss = emiss; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset             = v.rst;
        trace_enable      = v.te;
        sync_mode         = v.mode;
        sync_period       = v.per;
        inst_retire_valid = v.rv;
        inst_retire_cnt   = v.rc;
        pkt_emit_valid    = v.pv;
        pkt_emit_is_sync  = v.ps;
        sync_ack          = v.ack;
    endtask

    initial begin
        int n_wait;
        vec_t v;

        // Phase A: CYCLE_COUNT, period 4, no ack -> request after 4 edges, missed after 4 more
        vq.push_back(mk(1,0,2,4, 0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,0,2,4, 0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,0, 0,0,1));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,0, 0,0,2));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,0, 0,0,3));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,0, 1,0,0));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,0, 1,0,1));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,0, 1,0,2));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,0, 1,0,3));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,0, 1,1,0));
        vq.push_back(mk(0,1,2,4, 0,0,0,0,1, 0,1,1));
        vq.push_back(mk(0,0,2,4, 0,0,0,0,0, 0,0,0));
        // Phase B: IRETIRE_COUNT, period 10, 3 per cycle; 7 clamps to 4
        vq.push_back(mk(0,1,3,10, 1,3,0,0,0, 0,0,0));
        vq.push_back(mk(0,1,3,10, 1,3,0,0,0, 0,0,3));
        vq.push_back(mk(0,1,3,10, 1,3,0,0,0, 0,0,6));
        vq.push_back(mk(0,1,3,10, 1,3,0,0,0, 0,0,9));
        vq.push_back(mk(0,1,3,10, 1,3,0,0,0, 1,0,0));
        vq.push_back(mk(0,1,3,10, 1,7,0,0,0, 1,0,4));
        vq.push_back(mk(0,1,3,10, 0,7,0,0,0, 1,0,4));
        vq.push_back(mk(0,1,3,10, 1,7,0,0,1, 0,0,8));
        vq.push_back(mk(0,1,3,10, 1,4,0,0,0, 1,0,0));
        vq.push_back(mk(0,0,3,10, 1,4,0,0,0, 0,0,0));
        // Phase C: PKT_COUNT, period 3, sync packet restarts the count
        vq.push_back(mk(0,1,1,3, 0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,1,1,3, 0,0,1,0,0, 0,0,1));
        vq.push_back(mk(0,1,1,3, 0,0,1,0,0, 0,0,2));
        vq.push_back(mk(0,1,1,3, 0,0,1,1,0, 0,0,0));
        vq.push_back(mk(0,1,1,3, 0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,1,1,3, 0,0,1,0,0, 0,0,1));
        vq.push_back(mk(0,1,1,3, 0,0,1,0,0, 0,0,2));
        vq.push_back(mk(0,1,1,3, 0,0,1,0,0, 1,0,0));
        vq.push_back(mk(0,1,1,3, 0,0,0,0,1, 0,0,0));
        vq.push_back(mk(0,1,1,3, 0,0,0,0,0, 0,0,0));
        // Phase D: pending + missed, then sync packet coincident with a hit
        vq.push_back(mk(0,1,2,2, 0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,1,2,2, 0,0,0,0,0, 0,0,1));
        vq.push_back(mk(0,1,2,2, 0,0,0,0,0, 1,0,0));
        vq.push_back(mk(0,1,2,2, 0,0,0,0,0, 1,0,1));
        vq.push_back(mk(0,1,2,2, 0,0,0,0,0, 1,1,0));
        vq.push_back(mk(0,1,2,2, 0,0,0,0,0, 1,1,1));
        vq.push_back(mk(0,1,2,2, 0,0,1,1,0, 0,1,0));
        // Phase E: period 8 -> 5 at count 6, then SYNC_OFF and back
        vq.push_back(mk(0,1,2,8, 0,0,0,0,0, 0,1,0));
        for (int k = 1; k <= 6; k++) vq.push_back(mk(0,1,2,8, 0,0,0,0,0, 0,1,20'(k)));
        vq.push_back(mk(0,1,2,5, 0,0,0,0,0, 0,1,0));
        vq.push_back(mk(0,1,2,5, 0,0,0,0,0, 0,1,1));
        vq.push_back(mk(0,1,0,5, 0,0,0,0,0, 0,1,0));
        vq.push_back(mk(0,1,0,5, 0,0,0,0,0, 0,1,0));
        vq.push_back(mk(0,1,2,5, 0,0,0,0,0, 0,1,0));
        for (int k = 1; k <= 4; k++) vq.push_back(mk(0,1,2,5, 0,0,0,0,0, 0,1,20'(k)));
        vq.push_back(mk(0,1,2,5, 0,0,0,0,0, 1,1,0));
        // Phase F: reset with req and missed set, resume; then period 1
        vq.push_back(mk(1,1,2,5, 0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,1,2,5, 0,0,0,0,0, 0,0,1));
        vq.push_back(mk(0,1,2,5, 0,0,0,0,0, 0,0,2));
        vq.push_back(mk(0,1,2,1, 0,0,0,0,0, 0,0,0));
        vq.push_back(mk(0,1,2,1, 0,0,0,0,0, 1,0,0));
        vq.push_back(mk(0,1,2,1, 0,0,0,0,0, 1,1,0));
        vq.push_back(mk(0,0,2,1, 0,0,0,0,0, 0,0,0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(posedge clk);
            #1;
            check("sync_req",    i, 32'(sync_req),    32'(vq[i].ereq));
            check("sync_cause",  i, 32'(sync_cause),  vq[i].ereq ? 32'h2 : 32'h0);
            check("sync_missed", i, 32'(sync_missed), 32'(vq[i].emiss));
            check("count",       i, 32'(count),       32'(vq[i].ecnt));
        end

        // Hand sequence: period 6 with ack held high while idle-of-request; ack must be ignored until req rises
        v = mk(0,1,2,6, 0,0,0,0,1, 0,0,0);
        drive(v);
        @(posedge clk);
        #1;
        check("reconfig_count", 0, 32'(count), 32'h0);
        n_wait = 0;
        while (!sync_req && n_wait < 20) begin
            @(posedge clk);
            #1;
            n_wait++;
        end
        check("req_latency",  0, 32'(n_wait),     32'd6);
        check("req_cause",    0, 32'(sync_cause), 32'h2);
        check("hit_count",    0, 32'(count),      32'h0);
        @(posedge clk);
        #1;
        check("ack_drop_req", 0, 32'(sync_req),   32'h0);
        check("ack_drop_cnt", 0, 32'(count),      32'h1);
        check("ack_no_miss",  0, 32'(sync_missed), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
